// File: rtl/keccak_pkg.sv
// Shared types for the Keccak-f round sequencer, state mux and round pipeline.
package keccak_pkg;

    localparam int KECCAK_ROUNDS = 24;

    typedef logic [4:0] round_t;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } sched_state_t;

endpackage

// File: rtl/keccak_sched_wdog.sv
// Feedback watchdog for keccak_round_sched; only built when KECCAK_SCHED_WATCHDOG_EN is defined.
`ifdef KECCAK_SCHED_WATCHDOG_EN
module keccak_sched_wdog #(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam logic [7:0] LAST_COUNT = 8'(LIMIT - 1);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 8'd1;
        end
    end

    // Look-ahead so the sequencer leaves RUN on the edge where the count reaches LIMIT.
    assign expire = enable && !clear && (count == LAST_COUNT);

endmodule
`endif

// File: rtl/keccak_round_sched.sv
// Round sequencer for the Keccak-f state mux: issues round 0 from the absorb bus, then recirculates.
// Optional feedback watchdog enabled by defining KECCAK_SCHED_WATCHDOG_EN.
module keccak_round_sched
    import keccak_pkg::*;
#(
    parameter int ROUNDS      = KECCAK_ROUNDS,
    parameter int WDOG_CYCLES = 64
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   start,
    output logic   in_ready,
    input  logic   fb_good,
    input  round_t fb_round,
    output logic   mux_sample,
    output logic   mux_selector,
    output round_t mux_round,
    output logic   done,
    output logic   busy,
    output logic   err
);

    localparam round_t LAST_ROUND = round_t'(ROUNDS - 1);

    // Illegal parameter values fail elaboration on a deliberately missing module.
    if (ROUNDS < 1 || ROUNDS > 32 || WDOG_CYCLES < 1 || WDOG_CYCLES > 255) begin : g_param_check
        keccak_round_sched_illegal_parameter u_illegal ();
    end

    sched_state_t state;
    round_t       expected;
    logic         wdog_expire;

`ifdef KECCAK_SCHED_WATCHDOG_EN
    keccak_sched_wdog #(
        .LIMIT (WDOG_CYCLES)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (mux_sample),
        .enable ((state == RUN) && !fb_good),
        .expire (wdog_expire)
    );
`else
    assign wdog_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            expected     <= '0;
            in_ready     <= 1'b1;
            mux_sample   <= 1'b0;
            mux_selector <= 1'b0;
            mux_round    <= '0;
            done         <= 1'b0;
            busy         <= 1'b0;
            err          <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low here and are re-asserted by a branch, using <= so
            // every decision below sees pre-edge register values.
            mux_sample <= 1'b0;
            done       <= 1'b0;
            case (state)
                IDLE: begin
                    if (fb_good) begin
                        err <= 1'b1;
                    end
                    if (start) begin
                        state        <= RUN;
                        expected     <= '0;
                        in_ready     <= 1'b0;
                        busy         <= 1'b1;
                        mux_sample   <= 1'b1;
                        mux_selector <= 1'b0;
                        mux_round    <= '0;
                    end
                end
                RUN: begin
                    if (fb_good) begin
                        // A mismatched index is flagged but still counted as the expected round.
                        if (fb_round != expected) begin
                            err <= 1'b1;
                        end
                        if (expected == LAST_ROUND) begin
                            state    <= IDLE;
                            done     <= 1'b1;
                            in_ready <= 1'b1;
                            busy     <= 1'b0;
                        end else begin
                            expected     <= expected + round_t'(1);
                            mux_sample   <= 1'b1;
                            mux_selector <= 1'b1;
                            mux_round    <= expected + round_t'(1);
                        end
                    end else if (wdog_expire) begin
                        state    <= IDLE;
                        err      <= 1'b1;
                        in_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_round_sched.sv
// Directed bench for keccak_round_sched with a fixed-latency fake round pipeline.
module tb_keccak_round_sched;
    import keccak_pkg::*;

    localparam int ROUNDS = KECCAK_ROUNDS;
    localparam int WDOG   = 64;
    localparam int LAT    = 3;

    logic   clk = 1'b0;
    logic   rst;
    logic   start;
    logic   in_ready;
    logic   fb_good;
    round_t fb_round;
    logic   mux_sample;
    logic   mux_selector;
    round_t mux_round;
    logic   done;
    logic   busy;
    logic   err;

    always #5 clk = ~clk;

    keccak_round_sched #(
        .ROUNDS      (ROUNDS),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_ready     (in_ready),
        .fb_good      (fb_good),
        .fb_round     (fb_round),
        .mux_sample   (mux_sample),
        .mux_selector (mux_selector),
        .mux_round    (mux_round),
        .done         (done),
        .busy         (busy),
        .err          (err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Fake pipeline and observation state
    int     cyc          = 0;
    int     pend         = 0;
    round_t pend_round   = '0;
    int     bad_at       = -1;
    int     bad_val      = 0;
    int     withhold_from = -1;
    int     pulse_round  = -1;
    bit     pulse_now    = 0;
    int     seq_idx      = 0;
    int     n_samples    = 0;
    int     n_dones      = 0;
    int     done_cyc     = -1;
    int     fb_last_cyc  = -1;
    int     sample_cyc   = -1;

    // One clock: observe outputs #1 after the edge, then drive next inputs.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (done) begin
            n_dones++;
            done_cyc = cyc;
        end
        if (mux_sample) begin
            n_samples++;
            sample_cyc = cyc;
            check("sample_selector", mux_selector, (seq_idx != 0) ? 1 : 0);
            check("sample_round", mux_round, seq_idx);
            seq_idx = (seq_idx + 1 == ROUNDS) ? 0 : seq_idx + 1;
        end
        if (pulse_now) begin
            check("in_ready_at_ignored_start", in_ready, 0);
            pulse_now = 0;
            start = 1'b0;
        end
        if (pulse_round >= 0 && mux_sample && int'(mux_round) == pulse_round) begin
            start = 1'b1;
            pulse_now = 1;
        end
        fb_good = 1'b0;
        if (pend > 0) begin
            pend--;
            if (pend == 0) begin
                fb_good  = 1'b1;
                fb_round = (int'(pend_round) == bad_at) ? round_t'(bad_val) : pend_round;
                if (int'(pend_round) == ROUNDS - 1) fb_last_cyc = cyc;
            end
        end
        if (mux_sample && !(withhold_from >= 0 && int'(mux_round) >= withhold_from)) begin
            pend = LAT;
            pend_round = mux_round;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        fb_good = 1'b0;
        fb_round = '0;
        pend = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        seq_idx = 0;
        n_samples = 0;
        n_dones = 0;
        done_cyc = -1;
        fb_last_cyc = -1;
        pulse_now = 0;
    endtask

    task automatic run_perm();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 400 && n_dones == 0; i++) step();
        for (int i = 0; i < 4; i++) step();
    endtask

    typedef struct {
        int   bad_at;
        int   bad_val;
        int   pulse_round;
        int   exp_samples;
        int   exp_dones;
        logic exp_err;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{bad_at: -1, bad_val: 0, pulse_round: -1, exp_samples: 24, exp_dones: 1, exp_err: 1'b0};
        vecs[1] = '{bad_at: -1, bad_val: 0, pulse_round: 5,  exp_samples: 24, exp_dones: 1, exp_err: 1'b0};
        vecs[2] = '{bad_at: 4,  bad_val: 7, pulse_round: -1, exp_samples: 24, exp_dones: 1, exp_err: 1'b1};
        vecs[3] = '{bad_at: 23, bad_val: 0, pulse_round: -1, exp_samples: 24, exp_dones: 1, exp_err: 1'b1};

        rst = 1'b1;
        start = 1'b0;
        fb_good = 1'b0;
        fb_round = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_mux_sample", mux_sample, 0);
        check("rst_mux_selector", mux_selector, 0);
        check("rst_mux_round", mux_round, 0);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);

        // Table-driven permutations
        for (int v = 0; v < 4; v++) begin
            do_reset();
            bad_at = vecs[v].bad_at;
            bad_val = vecs[v].bad_val;
            pulse_round = vecs[v].pulse_round;
            run_perm();
            check("vec_samples", n_samples, vecs[v].exp_samples);
            check("vec_dones", n_dones, vecs[v].exp_dones);
            check("vec_err", err, vecs[v].exp_err);
            check("vec_done_latency", done_cyc, fb_last_cyc + 1);
            check("vec_busy_after", busy, 0);
            check("vec_in_ready_after", in_ready, 1);
        end
        bad_at = -1;
        pulse_round = -1;

        // Back-to-back with start held high
        do_reset();
        start = 1'b1;
        for (int i = 0; i < 400 && n_dones == 0; i++) step();
        check("b2b_first_done", n_dones, 1);
        check("b2b_no_sample_in_done_cycle", mux_sample, 0);
        check("b2b_in_ready_in_done_cycle", in_ready, 1);
        step();
        check("b2b_accept_one_after_done", mux_sample, 1);
        check("b2b_accept_cycle", sample_cyc, done_cyc + 1);
        start = 1'b0;
        for (int i = 0; i < 400 && n_dones < 2; i++) step();
        for (int i = 0; i < 4; i++) step();
        check("b2b_total_samples", n_samples, 48);
        check("b2b_total_dones", n_dones, 2);
        check("b2b_err", err, 0);

        // Reset in the middle of a permutation at round 10
        do_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 400 && !(mux_sample && mux_round == round_t'(10)); i++) step();
        check("mid_reached_round10", mux_round, 10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_mux_sample", mux_sample, 0);
        check("mid_rst_err_before_stray", err, 0);
        for (int i = 0; i < 8 && pend > 0; i++) step();
        step();
        check("mid_stray_fb_err", err, 1);
        seq_idx = 0;
        n_samples = 0;
        n_dones = 0;
        run_perm();
        check("mid_rerun_samples", n_samples, 24);
        check("mid_rerun_dones", n_dones, 1);
        check("mid_rerun_err_sticky", err, 1);

        // Feedback withheld after the round 2 issue
        do_reset();
        withhold_from = 2;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 400 && !(mux_sample && mux_round == round_t'(2)); i++) step();
        check("wd_reached_round2", mux_round, 2);
        begin
            int issue_cyc;
            issue_cyc = cyc;
`ifdef KECCAK_SCHED_WATCHDOG_EN
            for (int i = 0; i < 300 && !in_ready; i++) step();
            check("wd_timeout_cycle", cyc - issue_cyc, WDOG + 1);
            check("wd_err", err, 1);
            check("wd_busy", busy, 0);
            check("wd_no_done", n_dones, 0);
`else
            begin
                int idle_seen;
                idle_seen = 0;
                for (int i = 0; i < 200; i++) begin
                    step();
                    if (!busy || in_ready) idle_seen++;
                end
                check("nowd_busy_held", idle_seen, 0);
                check("nowd_elapsed", cyc - issue_cyc, 200);
                check("nowd_err", err, 0);
                check("nowd_no_done", n_dones, 0);
            end
`endif
        end
        withhold_from = -1;
        do_reset();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
